// File: rtl/dc_pwm.sv
// -----------------------------------------------------------------------------
// dc_pwm : complementary, dead-time protected PWM output stage
//
// Sits downstream of the controller datapath. A 14-bit two's-complement duty
// request is clamped to 0..PERIOD and captured into a shadow register. The
// shadow is transferred to the working duty register at the period boundary,
// so the duty in use never changes mid-period. A raw PWM waveform is derived
// from the period counter and passed through a dead-time generator that drives
// the high-side and low-side gates. The two gates are never high together.
//
// Parameters
//   PERIOD    PWM period in clk cycles (16..8191)
//   DEADTIME  both-gates-low cycles after each raw edge (1..255, < PERIOD/2)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   duty         two's-complement duty request (datapath dst bus)
//   duty_wr      one-cycle strobe, capture duty this cycle
//   en           PWM enable; 0 = idle with both gates off
//   pwm_hi       high-side gate drive
//   pwm_lo       low-side gate drive
//   cycle_start  one-cycle pulse while cnt==0 at the start of each period
//   duty_active  clamped duty value currently in use
// -----------------------------------------------------------------------------
module dc_pwm #(
   parameter int PERIOD   = 8191,
   parameter int DEADTIME = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] duty,
   input  logic        duty_wr,
   input  logic        en,
   output logic        pwm_hi,
   output logic        pwm_lo,
   output logic        cycle_start,
   output logic [12:0] duty_active
);

   localparam logic [12:0] PERIOD_C = 13'(PERIOD);
   localparam logic [12:0] LAST_C   = 13'(PERIOD - 1);
   localparam logic [7:0]  DT_C     = 8'(DEADTIME);

   // Negative requests mean "no drive"; anything above a full period is
   // saturated to 100 % duty.
   function automatic logic [12:0] clamp_duty(input logic signed [13:0] req);
      logic [12:0] res;
      if (req < 14'sd0) begin
         res = '0;
      end else if (req[12:0] > PERIOD_C) begin
         res = PERIOD_C;
      end else begin
         res = req[12:0];
      end
      return res;
   endfunction

   logic signed [13:0] duty_s;
   logic [12:0]        duty_clamped;

   assign duty_s       = $signed(duty);
   assign duty_clamped = clamp_duty(duty_s);

   // ---------------------------------------------------------------------------
   // Stage p0: period counter, shadow / working duty registers, period strobe
   // ---------------------------------------------------------------------------
   // run_p0 is en delayed by one cycle. The first cycle after an enable rise
   // holds cnt at 0 and launches cycle_start, so the strobe coincides with the
   // first counted cnt==0 cycle and every period is exactly PERIOD long.
   logic [12:0] cnt_p0;
   logic [12:0] shadow;
   logic        run_p0;
   logic        wrap_p0;

   assign wrap_p0 = en & run_p0 & (cnt_p0 == LAST_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0      <= '0;
         run_p0      <= 1'b0;
         cycle_start <= 1'b0;
         shadow      <= '0;
         duty_active <= '0;
      end else begin
         run_p0      <= en;
         cycle_start <= en & (~run_p0 | wrap_p0);

         if (en & run_p0) begin
            cnt_p0 <= wrap_p0 ? '0 : cnt_p0 + 13'd1;
         end else begin
            cnt_p0 <= '0;
         end

         // Last write in a period wins; writes are accepted while disabled.
         if (duty_wr) begin
            shadow <= duty_clamped;
         end

         // A write landing on the wrap cycle bypasses the shadow so it is not
         // delayed by a whole period.
         if (wrap_p0) begin
            duty_active <= duty_wr ? duty_clamped : shadow;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p1: raw PWM compare and its one-cycle history for edge detection
   // ---------------------------------------------------------------------------
   // The compare is gated with run_p0 so the held cnt==0 cycle after an enable
   // rise does not add an extra high cycle to the first period.
   logic raw_p1;
   logic raw_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_p1 <= 1'b0;
         raw_p2 <= 1'b0;
      end else begin
         raw_p1 <= en & run_p0 & (cnt_p0 < duty_active);
         raw_p2 <= raw_p1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p2: dead-time generator and gate drive
   // ---------------------------------------------------------------------------
   // Every raw edge reloads dt_cnt and blanks both gates. The gates are reloaded
   // from raw_p1 on the last counting cycle (dt_cnt==1) as well as when idle at
   // 0, giving exactly DEADTIME blanked cycles per edge. An edge arriving during
   // blanking restarts it, so pulses of DEADTIME cycles or less are swallowed.
   logic [7:0] dt_cnt;
   logic       raw_edge;

   assign raw_edge = raw_p1 ^ raw_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dt_cnt <= DT_C;
         pwm_hi <= 1'b0;
         pwm_lo <= 1'b0;
      end else if (!en || raw_edge) begin
         dt_cnt <= DT_C;
         pwm_hi <= 1'b0;
         pwm_lo <= 1'b0;
      end else begin
         if (dt_cnt != 8'd0) begin
            dt_cnt <= dt_cnt - 8'd1;
         end
         if (dt_cnt <= 8'd1) begin
            pwm_hi <= raw_p1;
            pwm_lo <= ~raw_p1;
         end else begin
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dc_pwm.sv
// -----------------------------------------------------------------------------
// tb_dc_pwm : directed self-checking bench for dc_pwm (PERIOD=1000, DEADTIME=16)
// -----------------------------------------------------------------------------
module tb_dc_pwm;

   localparam int PERIOD   = 1000;
   localparam int DEADTIME = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] duty = '0;
   logic        duty_wr = 1'b0;
   logic        en = 1'b0;
   logic        pwm_hi;
   logic        pwm_lo;
   logic        cycle_start;
   logic [12:0] duty_active;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dc_pwm #(
      .PERIOD   (PERIOD),
      .DEADTIME (DEADTIME)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .duty        (duty),
      .duty_wr     (duty_wr),
      .en          (en),
      .pwm_hi      (pwm_hi),
      .pwm_lo      (pwm_lo),
      .cycle_start (cycle_start),
      .duty_active (duty_active)
   );

   // Shoot-through guard, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         n_cmp++;
         assert (!(pwm_hi && pwm_lo)) else begin
            n_bad++;
            $error("FAIL shoot_through: observed hi=%b lo=%b required not both 1", pwm_hi, pwm_lo);
         end
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed time limit reached required completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cs(input string tag);
      int k;
      k = 0;
      step();
      while (!cycle_start && k < 1100) begin
         step();
         k++;
      end
      n_cmp++;
      assert (cycle_start === 1'b1) else begin
         n_bad++;
         $error("FAIL %s: observed cycle_start=%b after %0d cycles required 1", tag, cycle_start, k);
      end
   endtask

   // Observe one full period starting at a cnt==0 cycle; optional duty writes
   // at two cnt positions (-1 = none). Ends at cnt==0 of the next period.
   task automatic measure(input int w1, input logic [13:0] v1,
                          input int w2, input logic [13:0] v2,
                          output int hi_n, output int lo_n, output int cs_n,
                          output int da_last, output int lowrun);
      int run_len;
      hi_n = 0; lo_n = 0; cs_n = 0; da_last = 0; lowrun = 0; run_len = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (pwm_hi) hi_n++;
         if (pwm_lo) lo_n++;
         if (cycle_start) cs_n++;
         if (!pwm_hi && !pwm_lo) begin
            run_len++;
            if (run_len > lowrun) lowrun = run_len;
         end else begin
            run_len = 0;
         end
         if (i == PERIOD - 1) da_last = int'(duty_active);
         duty_wr = (i == w1) || (i == w2);
         if (i == w1) duty = v1;
         else if (i == w2) duty = v2;
         step();
      end
      duty_wr = 1'b0;
   endtask

   initial begin
      int h, l, c, d, r, k, g;

      // Reset state
      rst_n = 1'b0; en = 1'b0; duty = '0; duty_wr = 1'b0;
      repeat (3) step();
      check("rst_hi", pwm_hi, 0);
      check("rst_lo", pwm_lo, 0);
      check("rst_cs", cycle_start, 0);
      check("rst_da", duty_active, 0);

      // Steady duty 100, written while idle
      rst_n = 1'b1;
      step();
      duty = 14'd100; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      check("idle_write_da", duty_active, 0);
      en = 1'b1;
      k = 0;
      while (!(pwm_hi || pwm_lo) && k < 50) begin
         step();
         k++;
      end
      check("first_gate_delay", k, 16);
      check("first_gate_lo", pwm_lo, 1);
      wait_cs("cs_period2");
      check("steady_da", duty_active, 100);
      measure(-1, 14'd0, -1, 14'd0, h, l, c, d, r);
      check("steady_hi", h, 84);
      check("steady_lo", l, 884);
      check("steady_cs", c, 1);
      check("steady_lowrun", r, 16);
      check("steady_cs_next", cycle_start, 1);

      // Clamping: negative request
      measure(0, 14'h3F00, -1, 14'd0, h, l, c, d, r);
      check("neg_wr_same_period_hi", h, 84);
      check("neg_da", duty_active, 0);
      measure(0, 14'h1FFF, -1, 14'd0, h, l, c, d, r);
      check("neg_hi", h, 0);
      check("neg_lo", l, 1000);
      // Clamping: oversize request
      check("max_da", duty_active, 1000);
      measure(-1, 14'd0, -1, 14'd0, h, l, c, d, r);
      check("max_first_hi", h, 982);
      check("max_first_lo", l, 2);
      measure(0, 14'd100, -1, 14'd0, h, l, c, d, r);
      check("max_hi", h, 1000);
      check("max_lo", l, 0);

      // Double buffering: two writes in one period, last wins
      check("db_da_start", duty_active, 100);
      measure(500, 14'd300, 600, 14'd700, h, l, c, d, r);
      check("db_cur_hi", h, 102);
      check("db_cur_da_end", d, 100);
      check("db_next_da", duty_active, 700);
      measure(999, 14'd250, -1, 14'd0, h, l, c, d, r);
      check("db_next_hi", h, 684);
      check("db_wrap_da_end", d, 700);
      // Write on the wrap cycle takes effect at once
      check("wrap_bypass_da", duty_active, 250);
      measure(0, 14'd10, -1, 14'd0, h, l, c, d, r);
      check("wrap_bypass_hi", h, 234);

      // Narrow pulse swallowed by dead time
      check("narrow_da", duty_active, 10);
      measure(-1, 14'd0, -1, 14'd0, h, l, c, d, r);
      check("narrow_hi", h, 0);
      check("narrow_lo", l, 974);
      check("narrow_lowrun", r, 26);

      // Enable dropped at cnt=400
      repeat (400) step();
      check("pre_drop_lo", pwm_lo, 1);
      en = 1'b0;
      step();
      check("drop_hi", pwm_hi, 0);
      check("drop_lo", pwm_lo, 0);
      check("drop_cs", cycle_start, 0);
      duty = 14'd100; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      c = 0; g = 0;
      for (int i = 0; i < 1200; i++) begin
         if (cycle_start) c++;
         if (pwm_hi || pwm_lo) g++;
         step();
      end
      check("idle_cs_count", c, 0);
      check("idle_gate_count", g, 0);
      check("idle_da_kept", duty_active, 10);

      // Enable re-raised
      en = 1'b1;
      step();
      check("rise_cs", cycle_start, 1);
      k = 1;
      while (!(pwm_hi || pwm_lo) && k < 100) begin
         step();
         k++;
      end
      check("rise_first_gate", k, 29);
      check("rise_first_gate_lo", pwm_lo, 1);
      wait_cs("cs_after_rise");
      check("rise_da", duty_active, 100);
      measure(-1, 14'd0, -1, 14'd0, h, l, c, d, r);
      check("rise_hi", h, 84);
      check("rise_lo", l, 884);

      // Asynchronous reset mid-pulse
      repeat (50) step();
      check("pre_rst_hi", pwm_hi, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_hi", pwm_hi, 0);
      check("async_rst_lo", pwm_lo, 0);
      check("async_rst_cs", cycle_start, 0);
      check("async_rst_da", duty_active, 0);
      step();
      rst_n = 1'b1;
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
